// File: rtl/tmnt_layer_mixer.sv
// Pixel priority mixer: merges fix, tile A/B and sprite pixels into a palette index
// with shadow and blanking flags, two pixel-enable stages deep.
module tmnt_layer_mixer #(
    parameter logic [1:0] FIX_BANK = 2'b00,
    parameter logic [1:0] A_BANK   = 2'b01,
    parameter logic [1:0] B_BANK   = 2'b10,
    parameter logic [1:0] SPR_BANK = 2'b11
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ce_pix,
    input  logic [7:0] FIX_COL,
    input  logic [7:0] A_COL,
    input  logic [7:0] B_COL,
    input  logic [7:0] SPR_COL,
    input  logic       SPR_PRI,
    input  logic       SPR_SHD,
    input  logic       HBLANK,
    input  logic       VBLANK,
    input  logic       PRI_WR,
    input  logic       PRI_DIN,
    input  logic [3:0] LAYER_EN,
    output logic [9:0] CD,
    output logic       SHADOW,
    output logic       NCBLK
);

    logic       pri_q, pri_d;
    logic [7:0] fix_q, fix_d, a_q, a_d, b_q, b_d, spr_q, spr_d;
    logic [3:0] opq_q, opq_d;     // {spr, B, A, fix}
    logic [1:0] en_q, en_d;       // {B, A} enables, needed for the fallback colour
    logic       spr_pri_q, spr_pri_d, spr_shd_q, spr_shd_d;
    logic       pri1_q, pri1_d, blank1_q, blank1_d;
    logic [9:0] cd_q, cd_d;
    logic       shadow_q, shadow_d, ncblk_q, ncblk_d;

    logic       front_opq_s, back_opq_s, back_en_s;
    logic [7:0] front_col_s, back_col_s;
    logic [1:0] front_bank_s, back_bank_s;
    logic       spr_vis_s, spr_dark_s;

    // Priority register: CPU-written, independent of the pixel enable
    always_comb begin
        pri_d = pri_q;
        if (PRI_WR) begin
            pri_d = PRI_DIN;
        end else begin
            pri_d = pri_q;
        end
    end

    // Stage 1 capture: colours, opacity and blanking
    always_comb begin
        fix_d     = fix_q;
        a_d       = a_q;
        b_d       = b_q;
        spr_d     = spr_q;
        opq_d     = opq_q;
        en_d      = en_q;
        spr_pri_d = spr_pri_q;
        spr_shd_d = spr_shd_q;
        pri1_d    = pri1_q;
        blank1_d  = blank1_q;
        if (ce_pix) begin
            fix_d     = FIX_COL;
            a_d       = A_COL;
            b_d       = B_COL;
            spr_d     = SPR_COL;
            opq_d     = {(SPR_COL[3:0] != 4'h0) & LAYER_EN[3],
                         (B_COL[3:0]   != 4'h0) & LAYER_EN[2],
                         (A_COL[3:0]   != 4'h0) & LAYER_EN[1],
                         (FIX_COL[3:0] != 4'h0) & LAYER_EN[0]};
            en_d      = LAYER_EN[2:1];
            spr_pri_d = SPR_PRI;
            spr_shd_d = SPR_SHD;
            pri1_d    = pri_q;
            blank1_d  = HBLANK | VBLANK;
        end else begin
            fix_d = fix_q;
        end
    end

    // Front/back selection from the captured priority bit
    always_comb begin
        front_opq_s  = opq_q[1];
        front_col_s  = a_q;
        front_bank_s = A_BANK;
        back_opq_s   = opq_q[2];
        back_col_s   = b_q;
        back_bank_s  = B_BANK;
        back_en_s    = en_q[1];
        if (pri1_q) begin
            front_opq_s  = opq_q[2];
            front_col_s  = b_q;
            front_bank_s = B_BANK;
            back_opq_s   = opq_q[1];
            back_col_s   = a_q;
            back_bank_s  = A_BANK;
            back_en_s    = en_q[0];
        end else begin
            front_opq_s  = opq_q[1];
        end
        spr_vis_s  = opq_q[3] & ~spr_shd_q;
        spr_dark_s = opq_q[3] & spr_shd_q;
    end

    // Stage 2: winner resolution; a shadow sprite only marks, never occludes
    always_comb begin
        cd_d     = cd_q;
        shadow_d = shadow_q;
        ncblk_d  = ncblk_q;
        if (ce_pix) begin
            if (blank1_q) begin
                cd_d     = 10'h000;
                shadow_d = 1'b1;
                ncblk_d  = 1'b0;
            end else begin
                ncblk_d  = 1'b1;
                shadow_d = ~(spr_dark_s & ~opq_q[0] & (spr_pri_q | ~front_opq_s));
                if (opq_q[0]) begin
                    cd_d = {FIX_BANK, fix_q};
                end else if (spr_vis_s & spr_pri_q) begin
                    cd_d = {SPR_BANK, spr_q};
                end else if (front_opq_s) begin
                    cd_d = {front_bank_s, front_col_s};
                end else if (spr_vis_s) begin
                    cd_d = {SPR_BANK, spr_q};
                end else if (back_opq_s) begin
                    cd_d = {back_bank_s, back_col_s};
                end else if (back_en_s) begin
                    cd_d = {back_bank_s, back_col_s[7:4], 4'h0};
                end else begin
                    cd_d = 10'h000;
                end
            end
        end else begin
            cd_d = cd_q;
        end
    end

    // State registers
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            pri_q     <= 1'b0;
            fix_q     <= 8'h00;
            a_q       <= 8'h00;
            b_q       <= 8'h00;
            spr_q     <= 8'h00;
            opq_q     <= 4'h0;
            en_q      <= 2'b00;
            spr_pri_q <= 1'b0;
            spr_shd_q <= 1'b0;
            pri1_q    <= 1'b0;
            blank1_q  <= 1'b0;
            cd_q      <= 10'h000;
            shadow_q  <= 1'b1;
            ncblk_q   <= 1'b0;
        end else begin
            pri_q     <= pri_d;
            fix_q     <= fix_d;
            a_q       <= a_d;
            b_q       <= b_d;
            spr_q     <= spr_d;
            opq_q     <= opq_d;
            en_q      <= en_d;
            spr_pri_q <= spr_pri_d;
            spr_shd_q <= spr_shd_d;
            pri1_q    <= pri1_d;
            blank1_q  <= blank1_d;
            cd_q      <= cd_d;
            shadow_q  <= shadow_d;
            ncblk_q   <= ncblk_d;
        end
    end

    assign CD     = cd_q;
    assign SHADOW = shadow_q;
    assign NCBLK  = ncblk_q;

endmodule

// File: tb/tb_tmnt_layer_mixer.sv
// Bench for tmnt_layer_mixer: directed cases plus randomized pixels against a
// slot-ordered reference model with a two-deep expected-output pipeline.
module tb_tmnt_layer_mixer;

    logic       clk_sys  = 1'b0;
    logic       reset    = 1'b1;
    logic       ce_pix   = 1'b0;
    logic [7:0] FIX_COL  = 8'h00;
    logic [7:0] A_COL    = 8'h00;
    logic [7:0] B_COL    = 8'h00;
    logic [7:0] SPR_COL  = 8'h00;
    logic       SPR_PRI  = 1'b0;
    logic       SPR_SHD  = 1'b0;
    logic       HBLANK   = 1'b0;
    logic       VBLANK   = 1'b0;
    logic       PRI_WR   = 1'b0;
    logic       PRI_DIN  = 1'b0;
    logic [3:0] LAYER_EN = 4'hF;
    logic [9:0] CD;
    logic       SHADOW;
    logic       NCBLK;

    int errors = 0;
    int checks = 0;
    logic        pri_m   = 1'b0;
    logic [11:0] exp_s1  = 12'h000;
    logic [11:0] exp_out = 12'h000;
    int          vld     = 0;

    tmnt_layer_mixer dut (
        .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix),
        .FIX_COL(FIX_COL), .A_COL(A_COL), .B_COL(B_COL), .SPR_COL(SPR_COL),
        .SPR_PRI(SPR_PRI), .SPR_SHD(SPR_SHD), .HBLANK(HBLANK), .VBLANK(VBLANK),
        .PRI_WR(PRI_WR), .PRI_DIN(PRI_DIN), .LAYER_EN(LAYER_EN),
        .CD(CD), .SHADOW(SHADOW), .NCBLK(NCBLK)
    );

    always #5 clk_sys = ~clk_sys;

    // Walk the five priority slots in order; returns {CD, SHADOW, NCBLK}
    function automatic logic [11:0] model(
        input logic [7:0] fx, input logic [7:0] a, input logic [7:0] b, input logic [7:0] sp,
        input logic sp_pri, input logic sp_shd, input logic hb, input logic vb,
        input logic pri, input logic [3:0] en);
        logic [7:0] col [5];
        logic [1:0] bank [5];
        logic       opq [5];
        logic       is_spr [5];
        logic [7:0] back_col;
        logic [1:0] back_bank;
        logic       back_en;
        logic [9:0] cd;
        logic       shadow;
        logic       found;
        col[0] = fx; bank[0] = 2'b00; opq[0] = (fx[3:0] != 4'h0) && en[0]; is_spr[0] = 1'b0;
        col[1] = sp; bank[1] = 2'b11; opq[1] = (sp[3:0] != 4'h0) && en[3] && sp_pri; is_spr[1] = 1'b1;
        col[3] = sp; bank[3] = 2'b11; opq[3] = (sp[3:0] != 4'h0) && en[3] && !sp_pri; is_spr[3] = 1'b1;
        is_spr[2] = 1'b0; is_spr[4] = 1'b0;
        if (pri == 1'b0) begin
            col[2] = a; bank[2] = 2'b01; opq[2] = (a[3:0] != 4'h0) && en[1];
            col[4] = b; bank[4] = 2'b10; opq[4] = (b[3:0] != 4'h0) && en[2];
            back_en = en[2];
        end else begin
            col[2] = b; bank[2] = 2'b10; opq[2] = (b[3:0] != 4'h0) && en[2];
            col[4] = a; bank[4] = 2'b01; opq[4] = (a[3:0] != 4'h0) && en[1];
            back_en = en[1];
        end
        back_col = col[4];
        back_bank = bank[4];
        cd = 10'h000; shadow = 1'b1; found = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (!found && opq[i]) begin
                if (is_spr[i] && sp_shd) begin
                    shadow = 1'b0;
                end else begin
                    cd = {bank[i], col[i]};
                    found = 1'b1;
                end
            end
        end
        if (!found) begin
            cd = back_en ? {back_bank, back_col[7:4], 4'h0} : 10'h000;
        end
        if (hb || vb) begin
            return {10'h000, 1'b1, 1'b0};
        end
        return {cd, shadow, 1'b1};
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_model(input string tag);
        if (vld >= 2) begin
            chk({tag, "_cd"}, {2'b00, CD}, {2'b00, exp_out[11:2]});
            chk({tag, "_shadow"}, {11'h000, SHADOW}, {11'h000, exp_out[1]});
            chk({tag, "_ncblk"}, {11'h000, NCBLK}, {11'h000, exp_out[0]});
        end else begin
            vld = vld;
        end
    endtask

    task automatic expect_out(input string tag, input logic [9:0] cd, input logic sh, input logic nc);
        chk({tag, "_cd"}, {2'b00, CD}, {2'b00, cd});
        chk({tag, "_shadow"}, {11'h000, SHADOW}, {11'h000, sh});
        chk({tag, "_ncblk"}, {11'h000, NCBLK}, {11'h000, nc});
    endtask

    task automatic step(input logic ce, input logic wr, input logic din);
        ce_pix = ce; PRI_WR = wr; PRI_DIN = din;
        @(posedge clk_sys);
        #1;
        if (ce) begin
            exp_out = exp_s1;
            exp_s1 = model(FIX_COL, A_COL, B_COL, SPR_COL, SPR_PRI, SPR_SHD,
                           HBLANK, VBLANK, pri_m, LAYER_EN);
            if (vld < 2) vld++;
        end
        if (wr) pri_m = din;
        ce_pix = 1'b0; PRI_WR = 1'b0;
        check_model("model");
    endtask

    task automatic pulse();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_px(input logic [7:0] fx, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] sp, input logic sp_pri, input logic sp_shd);
        FIX_COL = fx; A_COL = a; B_COL = b; SPR_COL = sp; SPR_PRI = sp_pri; SPR_SHD = sp_shd;
    endtask

    function automatic logic [7:0] rnd_col();
        logic [7:0] c;
        c = 8'($urandom);
        if ($urandom_range(1, 0) == 0) c[3:0] = 4'h0;
        return c;
    endfunction

    initial begin
        // Reset state
        repeat (3) @(posedge clk_sys);
        #1;
        expect_out("reset", 10'h000, 1'b1, 1'b0);
        reset = 1'b0; vld = 0; pri_m = 1'b0;

        set_px(8'h35, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        pulse(); pulse();
        expect_out("fix_wins", 10'h035, 1'b1, 1'b1);

        set_px(8'h00, 8'h12, 8'h47, 8'h00, 1'b0, 1'b0);
        pulse(); pulse();
        expect_out("a_front", 10'h112, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        pulse(); pulse();
        expect_out("b_front", 10'h247, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);

        set_px(8'h00, 8'h12, 8'h47, 8'h9C, 1'b0, 1'b0);
        pulse(); pulse();
        expect_out("spr_low", 10'h112, 1'b1, 1'b1);
        SPR_PRI = 1'b1;
        pulse(); pulse();
        expect_out("spr_high", 10'h39C, 1'b1, 1'b1);

        set_px(8'h00, 8'h12, 8'h47, 8'h9F, 1'b1, 1'b1);
        pulse(); pulse();
        expect_out("shd_spr", 10'h112, 1'b0, 1'b1);
        FIX_COL = 8'h01;
        pulse(); pulse();
        expect_out("shd_under_fix", 10'h001, 1'b1, 1'b1);

        set_px(8'h00, 8'h00, 8'h70, 8'h00, 1'b0, 1'b0);
        pulse(); pulse();
        expect_out("fallback", 10'h270, 1'b1, 1'b1);
        LAYER_EN = 4'b1011;
        pulse(); pulse();
        expect_out("fallback_off", 10'h000, 1'b1, 1'b1);
        LAYER_EN = 4'hF;

        // One blanked pixel amid opaque data
        set_px(8'h00, 8'h12, 8'h47, 8'h00, 1'b0, 1'b0);
        pulse(); pulse();
        HBLANK = 1'b1;
        pulse();
        HBLANK = 1'b0;
        expect_out("blank_before", 10'h112, 1'b1, 1'b1);
        pulse();
        expect_out("blank_px", 10'h000, 1'b1, 1'b0);
        pulse();
        expect_out("blank_after", 10'h112, 1'b1, 1'b1);

        // Pixel enable held low: outputs hold despite new inputs
        set_px(8'h5A, 8'h33, 8'h44, 8'h66, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
        expect_out("ce_low_hold", 10'h112, 1'b1, 1'b1);

        // Priority write coincident with a pixel enable
        set_px(8'h00, 8'h12, 8'h47, 8'h00, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        pulse();
        expect_out("pri_coinc_old", 10'h112, 1'b1, 1'b1);
        pulse();
        expect_out("pri_coinc_new", 10'h247, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);

        // Randomized pixels, enable gaps, priority writes and a mid-line reset
        for (int n = 0; n < 300; n++) begin
            set_px(rnd_col(), rnd_col(), rnd_col(), rnd_col(),
                   1'($urandom), 1'($urandom_range(3, 0) == 0));
            HBLANK   = ($urandom_range(9, 0) == 0);
            VBLANK   = ($urandom_range(19, 0) == 0);
            LAYER_EN = ($urandom_range(3, 0) == 0) ? 4'($urandom) : 4'hF;
            step(1'b1, 1'($urandom_range(9, 0) == 0), 1'($urandom));
            for (int g = 0; g < int'($urandom_range(2, 1)); g++) begin
                step(1'b0, 1'($urandom_range(7, 0) == 0), 1'($urandom));
            end
            if (n == 150) begin
                #2 reset = 1'b1;
                #1;
                expect_out("mid_reset", 10'h000, 1'b1, 1'b0);
                @(posedge clk_sys);
                #1;
                reset = 1'b0; vld = 0; pri_m = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
